oam_dma: RTL and testbench

//  Sprite OAM DMA engine on the cpu_2a03 bus. A CPU write to $4014 halts the CPU
//  via RDY and copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port
//  ($2004), alternating bus reads and writes. It sits between the CPU core and
//  the memory/PPU bus and owns addr/rw/data while a transfer is running.

---
 rtl/nes_bus_pkg.sv | 20 ++
 rtl/dma_bus_mux.sv | 20 ++
 rtl/oam_dma.sv | 117 +++++++++++
 tb/tb_oam_dma.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared constants and state encoding for the cpu_2a03 bus side blocks:
// register addresses of the OAM data port and the sprite DMA trigger.
package nes_bus_pkg;

   localparam logic [15:0] OAM_ADDR     = 16'h2004;
   localparam logic [15:0] TRIGGER_ADDR = 16'h4014;

   // 9-bit so a full page count (256) is representable
   localparam logic [8:0]  XFER_LEN     = 9'd256;
   localparam logic [8:0]  LAST_COUNT   = XFER_LEN - 9'd1;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

endpackage

// File: rtl/dma_bus_mux.sv
// Shared bus steering: the DMA engine owns addr/rw/data while dma_active_i
// is high, otherwise the CPU core drives the bus.
module dma_bus_mux (
   input  logic        dma_active_i,
   input  logic [15:0] dma_addr_i,
   input  logic        dma_rw_i,
   input  logic [7:0]  dma_wdata_i,
   input  logic [15:0] cpu_addr_i,
   input  logic        cpu_rw_i,
   input  logic [7:0]  cpu_wdata_i,
   output logic [15:0] bus_addr_o,
   output logic        bus_rw_o,
   output logic [7:0]  bus_wdata_o
);

   assign bus_addr_o  = dma_active_i ? dma_addr_i  : cpu_addr_i;
   assign bus_rw_o    = dma_active_i ? dma_rw_i    : cpu_rw_i;
   assign bus_wdata_o = dma_active_i ? dma_wdata_i : cpu_wdata_i;

endmodule

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to $4014 halts the CPU and copies one 256-byte page
// to $2004. Define OAM_DMA_ALIGN_EN to insert the get/put alignment cycle.
module oam_dma
   import nes_bus_pkg::*;
(
   input  logic        clock,
   input  logic        nreset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_wdata,
   input  logic [7:0]  bus_rdata,
   output logic        cpu_rdy,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic        dma_rw,
   output logic [7:0]  dma_wdata,
   output dma_state_t  dbg_state
);

   dma_state_t  state_q;
   logic [7:0]  page_q;
   logic [8:0]  count_q;
   logic        parity_q;
   logic        cpu_rdy_q;
   logic        dma_active_q;
   logic [15:0] dma_addr_q;
   logic        dma_rw_q;
   logic [7:0]  dma_wdata_q;

   logic        parity_d;
   logic [8:0]  count_d;
   logic        trigger;
   logic        need_align;

   assign parity_d = ~parity_q;
   assign count_d  = count_q + 9'd1;
   assign trigger  = (cpu_addr == TRIGGER_ADDR) && !cpu_rw;

`ifdef OAM_DMA_ALIGN_EN
   // reads must land on get cycles; a put cycle next means one idle cycle first
   assign need_align = parity_d;
`else
   assign need_align = 1'b0;
`endif

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q      <= IDLE;
         page_q       <= 8'h00;
         count_q      <= 9'd0;
         parity_q     <= 1'b0;
         cpu_rdy_q    <= 1'b1;
         dma_active_q <= 1'b0;
         dma_addr_q   <= 16'h0000;
         dma_rw_q     <= 1'b1;
         dma_wdata_q  <= 8'h00;
      end else begin
         parity_q <= parity_d;
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  page_q    <= cpu_wdata;
                  count_q   <= 9'd0;
                  cpu_rdy_q <= 1'b0;
                  state_q   <= HALT;
               end
            end
            HALT: begin
               // the first CPU read cycle here is the dummy cycle
               if (cpu_rw) begin
                  if (need_align) begin
                     state_q <= ALIGN;
                  end else begin
                     state_q      <= READ;
                     dma_active_q <= 1'b1;
                     dma_rw_q     <= 1'b1;
                     dma_addr_q   <= {page_q, count_q[7:0]};
                  end
               end
            end
            ALIGN: begin
               state_q      <= READ;
               dma_active_q <= 1'b1;
               dma_rw_q     <= 1'b1;
               dma_addr_q   <= {page_q, count_q[7:0]};
            end
            READ: begin
               dma_wdata_q <= bus_rdata;
               dma_rw_q    <= 1'b0;
               dma_addr_q  <= OAM_ADDR;
               state_q     <= WRITE;
            end
            WRITE: begin
               count_q  <= count_d;
               dma_rw_q <= 1'b1;
               if (count_q == LAST_COUNT) begin
                  state_q      <= IDLE;
                  cpu_rdy_q    <= 1'b1;
                  dma_active_q <= 1'b0;
               end else begin
                  state_q    <= READ;
                  dma_addr_q <= {page_q, count_d[7:0]};
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_rdy    = cpu_rdy_q;
   assign dma_active = dma_active_q;
   assign dma_addr   = dma_addr_q;
   assign dma_rw     = dma_rw_q;
   assign dma_wdata  = dma_wdata_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma plus dma_bus_mux: a scripted CPU, a flat 64 KiB memory and a
// cycle-level reference of the expected bus trace for each sprite DMA.
module tb_oam_dma;
   import nes_bus_pkg::*;

`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        nreset = 1'b0;
   logic [15:0] cpu_addr = 16'h8000;
   logic        cpu_rw = 1'b1;
   logic [7:0]  cpu_wdata = 8'h00;
   logic [7:0]  bus_rdata;
   logic        cpu_rdy;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_rw;
   logic [7:0]  dma_wdata;
   dma_state_t  dbg_state;
   logic [15:0] bus_addr;
   logic        bus_rw;
   logic [7:0]  bus_wdata;

   logic [7:0]  mem [65536];
   int          cyc;
   int          total = 0;
   int          bad = 0;

   oam_dma dut (
      .clock      (clock),
      .nreset     (nreset),
      .cpu_addr   (cpu_addr),
      .cpu_rw     (cpu_rw),
      .cpu_wdata  (cpu_wdata),
      .bus_rdata  (bus_rdata),
      .cpu_rdy    (cpu_rdy),
      .dma_active (dma_active),
      .dma_addr   (dma_addr),
      .dma_rw     (dma_rw),
      .dma_wdata  (dma_wdata),
      .dbg_state  (dbg_state)
   );

   dma_bus_mux u_mux (
      .dma_active_i (dma_active),
      .dma_addr_i   (dma_addr),
      .dma_rw_i     (dma_rw),
      .dma_wdata_i  (dma_wdata),
      .cpu_addr_i   (cpu_addr),
      .cpu_rw_i     (cpu_rw),
      .cpu_wdata_i  (cpu_wdata),
      .bus_addr_o   (bus_addr),
      .bus_rw_o     (bus_rw),
      .bus_wdata_o  (bus_wdata)
   );

   assign bus_rdata = bus_rw ? mem[bus_addr] : 8'h00;

   // clock / reset-relative cycle index: parity of the cycle is cyc[0]
   always #5 clock = ~clock;

   always @(posedge clock or negedge nreset) begin
      if (!nreset) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pack(input logic rdy, input logic act, input logic rw,
                                        input logic [15:0] a, input logic [7:0] wd);
      return {5'd0, rdy, act, rw, a, (rw ? 8'h00 : wd)};
   endfunction

   function automatic logic [31:0] obs();
      return pack(cpu_rdy, dma_active, bus_rw, bus_addr, bus_wdata);
   endfunction

   // one CPU cycle: drive mid-cycle, sample 1 unit later (registered outputs are stable)
   task automatic cpu_step(input logic [15:0] a, input logic rw, input logic [7:0] wd);
      @(negedge clock);
      cpu_addr  = a;
      cpu_rw    = rw;
      cpu_wdata = wd;
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         cpu_step(16'h8000 | 16'($urandom_range(0, 16'h7fff)), 1'b1, 8'h00);
         check("idle", obs(), pack(1'b1, 1'b0, 1'b1, cpu_addr, 8'h00));
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] wd);
      cpu_step(a, 1'b0, wd);
      check("cpu_wr", obs(), pack(1'b1, 1'b0, 1'b0, a, wd));
   endtask

   // want_mis: -1 any phase, 0 first read on a get cycle, 1 on a put cycle
   // abort_at: -1 none, else pulse reset during the read of that byte index
   task automatic run_dma(input logic [7:0] page, input int n_extra,
                          input int want_mis, input int abort_at);
      int t, d, r, last, stall, i;
      logic [7:0]  ib;
      logic [31:0] exp;
      if (want_mis >= 0)
         while (((cyc + 3 + n_extra) % 2) != want_mis) idle_cycles(1);
      cpu_step(TRIGGER_ADDR, 1'b0, page);
      t = cyc;
      check("trigger", obs(), pack(1'b1, 1'b0, 1'b0, TRIGGER_ADDR, page));
      d = t + 1 + n_extra;
      r = d + 1;
      if (ALIGN_EN && (r % 2 == 1)) r = d + 2;
      last = r + 511;
      stall = 0;
      for (int c = t + 1; c <= last + 1; c++) begin
         if (c == t + 1 && n_extra > 0)
            cpu_step(TRIGGER_ADDR, 1'b0, ~page);
         else if (c < d)
            cpu_step(16'h0100 | 16'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)));
         else
            cpu_step(16'hC123, 1'b1, 8'h00);
         if (abort_at >= 0 && c == r + 2 * abort_at) begin
            nreset = 1'b0;
            #1;
            check("abort", obs(), pack(1'b1, 1'b0, cpu_rw, cpu_addr, cpu_wdata));
            @(negedge clock);
            nreset = 1'b1;
            return;
         end
         if (!cpu_rdy) stall++;
         if (c > last) begin
            exp = pack(1'b1, 1'b0, cpu_rw, cpu_addr, cpu_wdata);
         end else if (c >= r) begin
            i  = (c - r) / 2;
            ib = 8'(i);
            if (((c - r) % 2) == 0) exp = pack(1'b0, 1'b1, 1'b1, {page, ib}, 8'h00);
            else                    exp = pack(1'b0, 1'b1, 1'b0, OAM_ADDR, mem[{page, ib}]);
         end else begin
            exp = pack(1'b0, 1'b0, cpu_rw, cpu_addr, cpu_wdata);
         end
         check("beat", obs(), exp);
      end
      check("stall", 32'(stall), 32'(last - t));
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(0, 255));
      for (int a = 0; a < 256; a++) mem[16'hFF00 + a] = 8'(a);

      repeat (2) @(negedge clock);
      #1;
      check("rst_rdy", 32'(cpu_rdy), 32'd1);
      check("rst_act", 32'(dma_active), 32'd0);
      check("rst_addr", 32'(dma_addr), 32'd0);
      check("rst_rw", 32'(dma_rw), 32'd1);
      check("rst_wdata", 32'(dma_wdata), 32'd0);
      @(negedge clock);
      nreset = 1'b1;
      idle_cycles(3);

      // near-miss accesses must not start a transfer
      cpu_write(16'h4015, 8'h02);
      cpu_write(16'h4013, 8'h02);
      cpu_step(TRIGGER_ADDR, 1'b1, 8'h00);
      check("rd4014", obs(), pack(1'b1, 1'b0, 1'b1, TRIGGER_ADDR, 8'h00));
      idle_cycles(4);

      run_dma(8'h02, 0, 0, -1);
      idle_cycles(2);
      run_dma(8'h02, 0, 1, -1);
      idle_cycles(1);
      run_dma(8'h05, 2, 0, -1);
      idle_cycles(1);
      run_dma(8'h06, 2, 1, -1);
      idle_cycles(3);
      run_dma(8'hFF, 0, -1, -1);
      idle_cycles(2);

      run_dma(8'h03, 0, -1, 100);
      idle_cycles(2);
      run_dma(8'h03, 0, -1, -1);

      for (int k = 0; k < 4; k++) begin
         idle_cycles($urandom_range(0, 5));
         run_dma(8'($urandom_range(0, 255)), $urandom_range(0, 3), -1, -1);
      end
      idle_cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
